mips_run_ctrl: RTL and testbench

//  Parametrised clock-enable and reset sequencer for the MIPS core on the DE2 board.

---
 rtl/mips_run_pkg.sv | 19 +
 rtl/mips_debounce.sv | 45 ++++
 rtl/mips_run_ctrl.sv | 129 ++++++++++++
 tb/tb_mips_run_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_run_pkg.sv
// Shared mode and state encodings for the MIPS run/step controller.
package mips_run_pkg;

   typedef enum logic [1:0] {
      MODE_FREE  = 2'b00,
      MODE_DIV   = 2'b01,
      MODE_STEP  = 2'b10,
      MODE_BURST = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      S_RESET,
      S_IDLE,
      S_RUN,
      S_BURST,
      S_HALT
   } state_e;

endpackage

// File: rtl/mips_debounce.sv
// KEY debouncer: 2-FF synchroniser, stability counter, clean level and one-clock press pulse.
module mips_debounce #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn_n,
   output logic o_level,
   output logic o_fall_pulse
);

   localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_fall;

   // Counter only runs while the synchronised input disagrees with the accepted
   // level, so any bounce back to the old level restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= 2'b11;
         r_cnt   <= '0;
         r_level <= 1'b1;
         r_fall  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn_n};
         r_fall <= 1'b0;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
            r_fall  <= ~r_sync[1];
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_level      = r_level;
   assign o_fall_pulse = r_fall;

endmodule

// File: rtl/mips_run_ctrl.sv
// Reset stretcher and cpu_en sequencer (free / divided / single-step / burst) with optional cycle budget.
module mips_run_ctrl
   import mips_run_pkg::*;
#(
   parameter int RST_CYCLES = 4,
   parameter int CNT_W      = 32,
   parameter int DIV_W      = 16,
   parameter int DB_CYCLES  = 500000,
   parameter int MAX_CYCLES = 0
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [1:0]       mode_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             step_btn_n,
   input  logic             start_i,
   input  logic [CNT_W-1:0] burst_len_i,
   output logic             core_rst_o,
   output logic             cpu_en_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic             running_o,
   output logic             halted_o
);

   localparam int             RW     = $clog2(RST_CYCLES + 1);
   localparam bit             BUDGET = (MAX_CYCLES != 0);
   localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_CYCLES - 1);

   state_e           r_state, w_state_nx;
   logic [RW-1:0]    r_rst_cnt, w_rst_cnt_nx;
   logic [DIV_W-1:0] r_presc, w_presc_nx;
   logic [CNT_W-1:0] r_burst, w_burst_nx;
   logic [CNT_W-1:0] r_cyc;
   logic             r_cpu_en, r_start_q;
   logic             w_pulse, w_start_edge, w_db_level, w_db_fall;

   mips_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk          (CLOCK_50),
      .rst_n        (RESET_N),
      .i_btn_n      (step_btn_n),
      .o_level      (w_db_level),
      .o_fall_pulse (w_db_fall)
   );

   assign w_start_edge = start_i & ~r_start_q;

   always_comb begin
      w_state_nx   = r_state;
      w_rst_cnt_nx = r_rst_cnt;
      w_presc_nx   = r_presc;
      w_burst_nx   = r_burst;
      w_pulse      = 1'b0;
      case (r_state)
         S_RESET: begin
            w_presc_nx = '0;
            w_burst_nx = '0;
            if (r_rst_cnt == RW'(RST_CYCLES)) begin
               w_state_nx   = mode_i[1] ? S_IDLE : S_RUN;
               w_rst_cnt_nx = '0;
            end else begin
               w_rst_cnt_nx = r_rst_cnt + RW'(1);
            end
         end
         S_RUN: begin
            if (mode_i[1]) begin
               w_state_nx = S_IDLE;
               w_presc_nx = '0;
            end else if (mode_i == MODE_FREE || r_presc >= div_i) begin
               w_pulse    = 1'b1;
               w_presc_nx = '0;
            end else begin
               w_presc_nx = r_presc + DIV_W'(1);
            end
         end
         S_IDLE: begin
            if (!mode_i[1]) begin
               w_state_nx = S_RUN;
            end else if (mode_i == MODE_STEP) begin
               w_pulse = w_db_fall & ~w_db_level;
            end else if (w_start_edge && burst_len_i != '0) begin
               w_burst_nx = burst_len_i;
               w_state_nx = S_BURST;
            end
         end
         S_BURST: begin
            w_pulse    = 1'b1;
            w_burst_nx = r_burst - CNT_W'(1);
            if (r_burst == CNT_W'(1)) w_state_nx = S_IDLE;
         end
         S_HALT: begin
            // The restart edge itself is the first of the RST_CYCLES reset clocks.
            if (w_start_edge) begin
               w_state_nx   = S_RESET;
               w_rst_cnt_nx = RW'(1);
            end
         end
         default: w_state_nx = S_RESET;
      endcase
      if (BUDGET && w_pulse && r_cyc == MAX_M1) w_state_nx = S_HALT;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state   <= S_RESET;
         r_rst_cnt <= '0;
         r_presc   <= '0;
         r_burst   <= '0;
         r_cyc     <= '0;
         r_cpu_en  <= 1'b0;
         r_start_q <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_rst_cnt <= w_rst_cnt_nx;
         r_presc   <= w_presc_nx;
         r_burst   <= w_burst_nx;
         r_cpu_en  <= w_pulse;
         r_start_q <= start_i;
         if (w_state_nx == S_RESET) r_cyc <= '0;
         else if (w_pulse && !(&r_cyc)) r_cyc <= r_cyc + CNT_W'(1);
      end
   end

   assign core_rst_o  = (r_state == S_RESET);
   assign cpu_en_o    = r_cpu_en;
   assign cycle_cnt_o = r_cyc;
   assign running_o   = (r_state == S_RUN) || (r_state == S_BURST);
   assign halted_o    = (r_state == S_HALT);

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: reset stretch, divided run, step, burst, budget halt, reset mid-burst.
module tb_mips_run_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, rst2_n;
   logic [1:0]  mode, mode2;
   logic [15:0] div, div2;
   logic        btn, btn2, start, start2;
   logic [31:0] blen, blen2;
   logic        core_rst, cpu_en, running, halted;
   logic        core_rst2, cpu_en2, running2, halted2;
   logic [31:0] cnt, cnt2;
   int          n_cmp = 0;
   int          n_err = 0;
   int          npulse, pos;

   always #5 clk = ~clk;

   mips_run_ctrl #(.RST_CYCLES(4), .CNT_W(32), .DIV_W(16), .DB_CYCLES(4), .MAX_CYCLES(0)) dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .mode_i(mode), .div_i(div), .step_btn_n(btn),
      .start_i(start), .burst_len_i(blen), .core_rst_o(core_rst), .cpu_en_o(cpu_en),
      .cycle_cnt_o(cnt), .running_o(running), .halted_o(halted)
   );

   mips_run_ctrl #(.RST_CYCLES(4), .CNT_W(32), .DIV_W(16), .DB_CYCLES(4), .MAX_CYCLES(7)) dut2 (
      .CLOCK_50(clk), .RESET_N(rst2_n), .mode_i(mode2), .div_i(div2), .step_btn_n(btn2),
      .start_i(start2), .burst_len_i(blen2), .core_rst_o(core_rst2), .cpu_en_o(cpu_en2),
      .cycle_cnt_o(cnt2), .running_o(running2), .halted_o(halted2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) chk("rst_en_excl", {31'd0, core_rst & cpu_en}, 32'd0);
   end

   initial begin
      rst_n = 0; rst2_n = 0; mode = 2'b00; div = '0; btn = 1; start = 0; blen = '0;
      mode2 = 2'b00; div2 = '0; btn2 = 1; start2 = 0; blen2 = '0;
      repeat (3) tick();
      chk("rst_core_rst", core_rst, 1);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_running", running, 0);
      chk("rst_halted", halted, 0);

      // 1: reset stretch then free-run
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stretch_rst", core_rst, 1);
         chk("stretch_en", cpu_en, 0);
      end
      tick();
      chk("exit_rst", core_rst, 0);
      chk("exit_running", running, 1);
      chk("exit_en", cpu_en, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("free_en", cpu_en, 1);
      end
      chk("free_cnt", cnt, 10);

      // 2: divided by 4, then div 0 mid-count
      mode = 2'b01; div = 16'd3;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("div_en", cpu_en, (i % 4 == 3) ? 1 : 0);
      end
      div = 16'd0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("div0_en", cpu_en, 1);
      end
      chk("div_cnt", cnt, 16);

      // 3: single step with bounce
      mode = 2'b10;
      tick();
      chk("step_idle_en", cpu_en, 0);
      chk("step_idle_run", running, 0);
      btn = 0; tick();
      btn = 1; tick();
      btn = 0;
      npulse = 0; pos = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_en) begin npulse++; pos = i; end
      end
      chk("step_once", npulse, 1);
      chk("step_lat", {31'd0, (pos >= 5 && pos <= 6)}, 1);
      chk("step_cnt1", cnt, 17);
      btn = 1; npulse = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cpu_en) npulse++;
      end
      chk("step_release", npulse, 0);
      btn = 0; npulse = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cpu_en) npulse++;
      end
      chk("step_second", npulse, 1);
      chk("step_cnt2", cnt, 18);

      // 4: burst of 5, mode toggled mid-burst; then zero-length burst
      mode = 2'b11; blen = 32'd5;
      tick();
      start = 1;
      tick();
      chk("burst_enter_run", running, 1);
      chk("burst_enter_en", cpu_en, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("burst_en", cpu_en, 1);
         if (i == 1) mode = 2'b00;
         if (i == 3) mode = 2'b11;
      end
      tick();
      chk("burst_end_en", cpu_en, 0);
      chk("burst_end_run", running, 0);
      chk("burst_cnt", cnt, 23);
      start = 0; tick();
      blen = 32'd0; start = 1; npulse = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (cpu_en) npulse++;
      end
      chk("burst0_pulses", npulse, 0);
      chk("burst0_run", running, 0);

      // 6: async reset during pulse 3 of 10
      start = 0; blen = 32'd10; tick();
      start = 1; tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rb_en", cpu_en, 1);
      end
      #2 rst_n = 0;
      #1;
      chk("rb_core_rst", core_rst, 1);
      chk("rb_en_clr", cpu_en, 0);
      chk("rb_cnt_clr", cnt, 0);
      chk("rb_running", running, 0);
      chk("rb_halted", halted, 0);
      tick(); tick();
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rb_stretch", core_rst, 1);
      end
      tick();
      chk("rb_exit_rst", core_rst, 0);
      chk("rb_exit_idle", running, 0);
      npulse = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (cpu_en) npulse++;
      end
      chk("rb_no_leftover", npulse, 0);
      chk("rb_cnt", cnt, 0);

      // 5: cycle budget of 7 on the second instance
      rst2_n = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bud_stretch", core_rst2, 1);
      end
      tick();
      chk("bud_exit_rst", core_rst2, 0);
      chk("bud_exit_en", cpu_en2, 0);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("bud_en", cpu_en2, 1);
      end
      chk("bud_halted", halted2, 1);
      chk("bud_cnt", cnt2, 7);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bud_halt_en", cpu_en2, 0);
         chk("bud_halt_flag", halted2, 1);
      end
      chk("bud_halt_cnt", cnt2, 7);
      start2 = 1;
      tick();
      chk("bud_rst", core_rst2, 1);
      chk("bud_rst_cnt", cnt2, 0);
      chk("bud_rst_halt", halted2, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bud_rst_hold", core_rst2, 1);
      end
      tick();
      chk("bud_rst_exit", core_rst2, 0);
      chk("bud_resume_run", running2, 1);
      tick();
      chk("bud_resume_en", cpu_en2, 1);
      chk("bud_resume_cnt", cnt2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
